// File: rtl/bp_be_perf_report_arbiter.sv
// Per-core cycle/instruction counters with finish-edge snapshots, arbitrated round-robin
// onto one report channel. Define BP_BE_PERF_MIPC_EN to add the serial mIPC divider.

module bp_be_perf_core_cnt #(
  parameter int cnt_width_p = 64
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   commit_i,
  input  logic                   finish_i,
  input  logic                   capture_i,
  output logic                   rise_o,
  output logic [cnt_width_p-1:0] snap_clk_o,
  output logic [cnt_width_p-1:0] snap_instr_o
);
  logic [cnt_width_p-1:0] clk_q, instr_q, snap_clk_q, snap_instr_q;
  logic                   prev_q;

  assign rise_o       = finish_i & ~prev_q;
  assign snap_clk_o   = snap_clk_q;
  assign snap_instr_o = snap_instr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clk_q        <= '0;
      instr_q      <= '0;
      snap_clk_q   <= '0;
      snap_instr_q <= '0;
      prev_q       <= 1'b0;
    end else begin
      prev_q <= finish_i;
      if (!finish_i) begin
        clk_q   <= clk_q + 1'b1;
        instr_q <= instr_q + cnt_width_p'(commit_i);
      end
      // Snapshot holds the counts at the start of the edge cycle
      if (capture_i) begin
        snap_clk_q   <= clk_q;
        snap_instr_q <= instr_q;
      end
    end
  end
endmodule

module bp_be_perf_report_arbiter #(
  parameter int num_core_p  = 1,
  parameter int cnt_width_p = 64,
  localparam int CW = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   freeze_i,
  input  logic [num_core_p-1:0]  commit_v_i,
  input  logic [num_core_p-1:0]  program_finish_i,
  output logic                   report_v_o,
  input  logic                   report_ready_i,
  output logic [CW-1:0]          report_core_o,
  output logic [cnt_width_p-1:0] report_clk_o,
  output logic [cnt_width_p-1:0] report_instr_o,
  output logic [cnt_width_p-1:0] report_mipc_o
);
  localparam int W = cnt_width_p;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_SEND} state_e;

  state_e                          state_q, state_d;
  logic                            rst, hs, grant_v;
  logic [num_core_p-1:0]           rise, capture, clr, pend_keep, pending_q, pending_d;
  logic [num_core_p-1:0][W-1:0]    snap_clk, snap_instr;
  logic [CW-1:0]                   rr_q, gnt_d, grant_q;
  logic [W-1:0]                    rep_clk_q, rep_instr_q;
  int                              idx;
  logic                            found;

  assign rst = reset_i | freeze_i;

  for (genvar k = 0; k < num_core_p; k++) begin : g_core
    bp_be_perf_core_cnt #(.cnt_width_p(W)) u_cnt (
      .clk_i       (clk_i),
      .reset_i     (rst),
      .commit_i    (commit_v_i[k]),
      .finish_i    (program_finish_i[k]),
      .capture_i   (capture[k]),
      .rise_o      (rise[k]),
      .snap_clk_o  (snap_clk[k]),
      .snap_instr_o(snap_instr[k])
    );
  end

  // Clear-then-set so an edge on the granted core in its handshake cycle is kept
  assign hs        = (state_q == S_SEND) & report_ready_i;
  assign clr       = hs ? (num_core_p'(1) << grant_q) : '0;
  assign pend_keep = pending_q & ~clr;
  assign capture   = rise & ~pend_keep;
  assign pending_d = pend_keep | capture;

  always_comb begin
    gnt_d = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < num_core_p; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= num_core_p) idx = idx - num_core_p;
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        gnt_d = CW'(idx);
      end
    end
  end

  assign grant_v = (state_q == S_IDLE) & (|pending_q);

`ifdef BP_BE_PERF_MIPC_EN
  localparam int DCW = $clog2(W) + 1;
  logic [DCW-1:0] div_cnt_q;
  logic [W-1:0]   quot_q, rem_q;
  logic [W:0]     rem_sh, diff;

  assign rem_sh = {rem_q, quot_q[W-1]};
  assign diff   = rem_sh - {1'b0, rep_clk_q};

  // Restoring divide; a zero divisor never underflows, giving all ones
  always_ff @(posedge clk_i) begin
    if (rst) begin
      div_cnt_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
    end else if (grant_v) begin
      div_cnt_q <= '0;
      quot_q    <= W'(snap_instr[gnt_d] * W'(1000));
      rem_q     <= '0;
    end else if (state_q == S_DIV) begin
      div_cnt_q <= div_cnt_q + 1'b1;
      if (!diff[W]) begin
        rem_q  <= diff[W-1:0];
        quot_q <= {quot_q[W-2:0], 1'b1};
      end else begin
        rem_q  <= rem_sh[W-1:0];
        quot_q <= {quot_q[W-2:0], 1'b0};
      end
    end
  end

  assign report_mipc_o = quot_q;
`else
  assign report_mipc_o = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
`ifdef BP_BE_PERF_MIPC_EN
        if (|pending_q) state_d = S_DIV;
      S_DIV:
        if (div_cnt_q == DCW'(W - 1)) state_d = S_SEND;
`else
        if (|pending_q) state_d = S_SEND;
`endif
      S_SEND:
        if (report_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    report_v_o = (state_q == S_SEND);
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      pending_q   <= '0;
      rr_q        <= '0;
      grant_q     <= '0;
      rep_clk_q   <= '0;
      rep_instr_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (grant_v) begin
        grant_q     <= gnt_d;
        rep_clk_q   <= snap_clk[gnt_d];
        rep_instr_q <= snap_instr[gnt_d];
      end
      if (hs) rr_q <= (grant_q == CW'(num_core_p - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  assign report_core_o  = grant_q;
  assign report_clk_o   = rep_clk_q;
  assign report_instr_o = rep_instr_q;
endmodule

// File: tb/tb_bp_be_perf_report_arbiter.sv
// Directed bench for the perf report arbiter: latency, round-robin, backpressure, reset abort.
module tb_bp_be_perf_report_arbiter;
  localparam int N = 4;
  localparam int W = 64;
`ifdef BP_BE_PERF_MIPC_EN
  localparam int LAT  = 2 + W;
  localparam bit MIPC = 1'b1;
`else
  localparam int LAT  = 2;
  localparam bit MIPC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_i, freeze_i, report_ready_i, report_v_o;
  logic [N-1:0] commit_v_i, program_finish_i;
  logic [1:0]   report_core_o;
  logic [W-1:0] report_clk_o, report_instr_o, report_mipc_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  bp_be_perf_report_arbiter #(.num_core_p(N), .cnt_width_p(W)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .freeze_i        (freeze_i),
    .commit_v_i      (commit_v_i),
    .program_finish_i(program_finish_i),
    .report_v_o      (report_v_o),
    .report_ready_i  (report_ready_i),
    .report_core_o   (report_core_o),
    .report_clk_o    (report_clk_o),
    .report_instr_o  (report_instr_o),
    .report_mipc_o   (report_mipc_o)
  );

  task automatic tick;
    @(negedge clk);
    cyc++;
  endtask

  // Leaves us at the negedge of cycle 0 (first cycle out of reset)
  task automatic do_reset(input logic [N-1:0] fin);
    reset_i = 1'b1; freeze_i = 1'b0; commit_v_i = '0;
    program_finish_i = '0; report_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    program_finish_i = fin;
    reset_i = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_v(input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound; k++) begin
      if (report_v_o) begin at = cyc; break; end
      tick;
    end
  endtask

  task automatic test_reset;
    int at;
    reset_i = 1'b1; commit_v_i = '1; program_finish_i = '1; report_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({report_v_o, report_core_o, report_clk_o, report_instr_o, report_mipc_o} !== '0) begin
      fails++; $display("FAIL reset_outputs: got v=%0b clk=%0d want all zero", report_v_o, report_clk_o);
    end
    do_reset('0);
    while (cyc < 2) tick;
    program_finish_i[0] = 1'b1;
    wait_v(200, at);
    tests++;
    if (at != 2 + LAT) begin
      fails++; $display("FAIL freeze_pre_beat: got cycle %0d want %0d", at, 2 + LAT);
    end
    freeze_i = 1'b1; program_finish_i = '0;
    tick;
    tests++;
    if ({report_v_o, report_core_o, report_clk_o, report_instr_o, report_mipc_o} !== '0) begin
      fails++; $display("FAIL freeze_outputs: got v=%0b clk=%0d want all zero", report_v_o, report_clk_o);
    end
    freeze_i = 1'b0;
  endtask

  task automatic test_single;
    int got = -1;
    int beats = 0;
    logic [W-1:0] c, i, m;
    logic [1:0] core;
    do_reset('0);
    report_ready_i = 1'b1;
    for (int k = 0; k < 400 && got < 0; k++) begin
      commit_v_i[0]       = (cyc < 100) && (cyc % 2 == 0);
      program_finish_i[0] = (cyc >= 100);
      if (report_v_o) begin
        got = cyc; c = report_clk_o; i = report_instr_o; m = report_mipc_o; core = report_core_o;
      end
      tick;
    end
    tests++;
    if (got != 100 + LAT) begin fails++; $display("FAIL single_latency: got %0d want %0d", got, 100 + LAT); end
    tests++;
    if (c !== 64'd100) begin fails++; $display("FAIL single_clk: got %0d want 100", c); end
    tests++;
    if (i !== 64'd50) begin fails++; $display("FAIL single_instr: got %0d want 50", i); end
    tests++;
    if (core !== 2'd0) begin fails++; $display("FAIL single_core: got %0d want 0", core); end
    tests++;
    if (m !== (MIPC ? 64'd500 : 64'd0)) begin
      fails++; $display("FAIL single_mipc: got %0d want %0d", m, MIPC ? 500 : 0);
    end
    for (int k = 0; k < 100; k++) begin
      if (report_v_o) beats++;
      tick;
    end
    tests++;
    if (beats != 0) begin fails++; $display("FAIL single_no_repeat: got %0d extra beats want 0", beats); end
  endtask

  task automatic test_round_robin;
    int order[$];
    logic [W-1:0] clks[$];
    int fin0 = -1;
    bit prevv = 1'b0;
    bit b2b = 1'b0;
    do_reset('0);
    report_ready_i = 1'b1;
    for (int k = 0; k < 800 && order.size() < 4; k++) begin
      program_finish_i[3:1] = (cyc >= 5) ? 3'b111 : 3'b000;
      if (report_v_o) begin
        if (prevv) b2b = 1'b1;
        order.push_back(int'(report_core_o));
        clks.push_back(report_clk_o);
      end
      if (order.size() == 3 && fin0 < 0) fin0 = cyc;
      program_finish_i[0] = (fin0 >= 0);
      prevv = report_v_o;
      tick;
    end
    tests++;
    if (order.size() != 4) begin
      fails++; $display("FAIL rr_count: got %0d beats want 4", order.size());
    end else begin
      tests++;
      if (order[0] != 1 || order[1] != 2 || order[2] != 3 || order[3] != 0) begin
        fails++; $display("FAIL rr_order: got %0d,%0d,%0d,%0d want 1,2,3,0", order[0], order[1], order[2], order[3]);
      end
      tests++;
      if (clks[0] !== 64'd5 || clks[1] !== 64'd5 || clks[2] !== 64'd5) begin
        fails++; $display("FAIL rr_clk: got %0d,%0d,%0d want 5,5,5", clks[0], clks[1], clks[2]);
      end
      tests++;
      if (clks[3] !== W'(fin0)) begin fails++; $display("FAIL rr_core0_clk: got %0d want %0d", clks[3], fin0); end
    end
    tests++;
    if (b2b) begin fails++; $display("FAIL rr_idle_gap: got back-to-back beats want a gap"); end
  endtask

  task automatic test_backpressure;
    int at, at2, f2;
    bit unstable = 1'b0;
    logic [W-1:0] c0, i0, m0;
    logic [1:0] k0;
    do_reset('0);
    while (cyc < 3) tick;
    program_finish_i[1] = 1'b1;
    wait_v(200, at);
    c0 = report_clk_o; i0 = report_instr_o; m0 = report_mipc_o; k0 = report_core_o;
    tests++;
    if (at < 0 || k0 !== 2'd1 || c0 !== 64'd3) begin
      fails++; $display("FAIL bp_first: got at=%0d core=%0d clk=%0d want core 1 clk 3", at, k0, c0);
    end
    f2 = -1;
    for (int k = 0; k < 20; k++) begin
      if (!report_v_o || report_clk_o !== c0 || report_instr_o !== i0 ||
          report_mipc_o !== m0 || report_core_o !== k0) unstable = 1'b1;
      if (k == 5) begin program_finish_i[2] = 1'b1; f2 = cyc; end
      tick;
    end
    tests++;
    if (unstable) begin fails++; $display("FAIL bp_stable: got fields changing want stable"); end
    report_ready_i = 1'b1;
    tick;
    tests++;
    if (report_v_o !== 1'b0) begin fails++; $display("FAIL bp_gap: got v=%0b want 0", report_v_o); end
    wait_v(200, at2);
    tests++;
    if (at2 < 0 || report_core_o !== 2'd2 || report_clk_o !== W'(f2)) begin
      fails++; $display("FAIL bp_second: got at=%0d core=%0d clk=%0d want core 2 clk %0d", at2, report_core_o, report_clk_o, f2);
    end
  endtask

  task automatic test_zero_clk;
    int at;
    do_reset(4'b0001);
    report_ready_i = 1'b1;
    wait_v(200, at);
    tests++;
    if (at != LAT) begin fails++; $display("FAIL zero_latency: got %0d want %0d", at, LAT); end
    tests++;
    if (report_clk_o !== '0 || report_instr_o !== '0 || report_core_o !== 2'd0) begin
      fails++; $display("FAIL zero_fields: got clk=%0d instr=%0d want 0,0", report_clk_o, report_instr_o);
    end
    tests++;
    if (report_mipc_o !== (MIPC ? {W{1'b1}} : {W{1'b0}})) begin
      fails++; $display("FAIL zero_mipc: got %0h want %0h", report_mipc_o, MIPC ? {W{1'b1}} : {W{1'b0}});
    end
  endtask

  task automatic test_reset_abort;
    int at;
    int beats = 0;
    do_reset('0);
    while (cyc < 3) tick;
    program_finish_i[1] = 1'b1;
    while (cyc < 6) tick;
    do_reset('0);
    for (int k = 0; k < 90; k++) begin
      if (report_v_o) beats++;
      tick;
    end
    tests++;
    if (beats != 0) begin fails++; $display("FAIL abort_no_beat: got %0d beats want 0", beats); end
    program_finish_i[1] = 1'b1;
    wait_v(200, at);
    tests++;
    if (at != 90 + LAT || report_core_o !== 2'd1 || report_clk_o !== 64'd90) begin
      fails++; $display("FAIL abort_fresh: got at=%0d core=%0d clk=%0d want at %0d core 1 clk 90", at, report_core_o, report_clk_o, 90 + LAT);
    end
  endtask

  initial begin
    reset_i = 1'b1; freeze_i = 1'b0; commit_v_i = '0;
    program_finish_i = '0; report_ready_i = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_zero_clk;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
